control_plane_tdm: RTL and testbench



---
 rtl/cp_pkg.sv | 28 ++
 rtl/cp_slot_timer.sv | 33 +++
 rtl/control_plane_tdm.sv | 209 ++++++++++++++++++++
 tb/tb_control_plane_tdm.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp_pkg.sv
// Shared types for the TDM control plane: packet layout, response codes and tx FSM states.
package cp_pkg;

  localparam int CP_ID_W = 16;

  // Control packet: the ID_W parameter of control_plane_tdm must equal CP_ID_W.
  typedef struct packed {
    logic [CP_ID_W-1:0] dest;
    logic [CP_ID_W-1:0] src;
  } cp_pkt_t;

  localparam logic [CP_ID_W-1:0] RESP_GRANT = '1;
  localparam logic [CP_ID_W-1:0] RESP_DENY  = '0;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PING    = 3'd1,
    WAIT    = 3'd2,
    GRANTED = 3'd3,
    BACKOFF = 3'd4
  } cp_tx_state_e;

  // The response codes double as reserved source ids, so they can never start a ping.
  function automatic logic is_ping_src(input logic [CP_ID_W-1:0] src);
    return (src != RESP_DENY) && (src != RESP_GRANT);
  endfunction

endpackage

// File: rtl/cp_slot_timer.sv
// Control-plane slot ring timer: cycle-within-slot counter and 1..max_node slot number.
module cp_slot_timer #(
  parameter int ID_W        = 16,
  parameter int SLOT_CYCLES = 3,
  parameter int CYC_W       = $clog2(SLOT_CYCLES)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [ID_W-1:0] node_id,
  input  logic [ID_W-1:0] max_node,
  output logic [CYC_W-1:0] cyc,
  output logic [ID_W-1:0] slot,
  output logic            own_slot,
  output logic            slot_wrap
);

  assign slot_wrap = (cyc == CYC_W'(SLOT_CYCLES - 1));
  assign own_slot  = (slot == node_id);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc  <= '0;
      slot <= ID_W'(1);
    end else if (slot_wrap) begin
      cyc  <= '0;
      slot <= (slot >= max_node) ? ID_W'(1) : slot + ID_W'(1);
    end else begin
      cyc <= cyc + CYC_W'(1);
    end
  end

endmodule

// File: rtl/control_plane_tdm.sv
// TDM control-plane arbiter: pings a destination in the own slot with timed retry,
// answers pings from other nodes, and drives data-plane and GPP gating flags.
module control_plane_tdm
  import cp_pkg::*;
#(
  parameter int ID_W          = CP_ID_W,
  parameter int SLOT_CYCLES   = 3,
  parameter int RESP_TIMEOUT  = 8,
  parameter int MAX_RETRY     = 3,
  parameter int BACKOFF_SLOTS = 1,
  parameter int TRF_MIN_SLOTS = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ID_W-1:0]   node_id,
  input  logic [ID_W-1:0]   max_node,
  input  logic [2*ID_W-1:0] control_rx_packet,
  input  logic              tx_pending,
  input  logic [ID_W-1:0]   tx_dest_id,
  input  logic              data_tx_complete_flag,
  input  logic              data_rx_complete_flag,
  input  logic              gpp_rtr_cp,
  output logic [2*ID_W-1:0] control_tx_packet,
  output logic [ID_W-1:0]   data_rx_node_id,
  output logic              data_tx_flag,
  output logic              data_rx_flag,
  output logic              tx_fail,
  output logic              gpp_trf_cp
);

  localparam int CYC_W   = $clog2(SLOT_CYCLES);
  localparam int RETRY_W = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);
  localparam int WAIT_W  = (RESP_TIMEOUT < 2) ? 1 : $clog2(RESP_TIMEOUT + 1);
  localparam int BO_W    = (BACKOFF_SLOTS < 2) ? 1 : $clog2(BACKOFF_SLOTS + 1);

  logic [CYC_W-1:0] cyc;
  logic [ID_W-1:0]  slot;
  logic             own_slot;
  logic             slot_wrap;

  cp_slot_timer #(
    .ID_W        (ID_W),
    .SLOT_CYCLES (SLOT_CYCLES),
    .CYC_W       (CYC_W)
  ) u_slot_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .node_id   (node_id),
    .max_node  (max_node),
    .cyc       (cyc),
    .slot      (slot),
    .own_slot  (own_slot),
    .slot_wrap (slot_wrap)
  );

  // ---------------- Rx side: answer pings addressed to this node ----------------
  cp_pkt_t rx_pkt;
  cp_pkt_t resp_pkt;
  logic    resp_valid;
  logic    rx_ping;
  logic    rx_grant;
  logic    rx_resp;

  assign rx_pkt   = control_rx_packet;
  assign rx_ping  = (rx_pkt.dest == node_id) && is_ping_src(rx_pkt.src);
  // resp_valid marks a ping in the previous cycle, so back-to-back pings lose.
  assign rx_grant = rx_ping && !data_rx_flag && !gpp_rtr_cp && !resp_valid;
  assign rx_resp  = (rx_pkt.dest == node_id) && !is_ping_src(rx_pkt.src);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid      <= 1'b0;
      resp_pkt        <= '0;
      data_rx_flag    <= 1'b0;
      data_rx_node_id <= '0;
    end else begin
      resp_valid    <= rx_ping;
      resp_pkt.dest <= rx_pkt.src;
      resp_pkt.src  <= rx_grant ? RESP_GRANT : RESP_DENY;
      if (rx_grant) begin
        data_rx_flag    <= 1'b1;
        data_rx_node_id <= rx_pkt.src;
      end else if (data_rx_complete_flag) begin
        data_rx_flag <= 1'b0;
      end
    end
  end

  // ---------------- Tx FSM: ping, wait, retry with backoff ----------------
  cp_tx_state_e         state, state_n;
  logic [RETRY_W-1:0]   retry_cnt, retry_n;
  logic [WAIT_W-1:0]    wait_cnt, wait_n;
  logic [BO_W-1:0]      bo_cnt, bo_n;
  logic                 tx_flag_n;
  logic                 fail_n;
  logic                 ping_fire;
  cp_pkt_t              ping_pkt;

  assign ping_fire = (state == PING) && tx_pending && own_slot && !resp_valid;

  always_comb begin
    ping_pkt.dest = tx_dest_id;
    ping_pkt.src  = node_id;
    control_tx_packet = '0;
    if (resp_valid)     control_tx_packet = resp_pkt;
    else if (ping_fire) control_tx_packet = ping_pkt;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_n   = state;
    retry_n   = retry_cnt;
    wait_n    = wait_cnt;
    bo_n      = bo_cnt;
    tx_flag_n = data_tx_flag;
    fail_n    = 1'b0;
    unique case (state)
      IDLE: begin
        if (own_slot && tx_pending && !data_tx_flag) state_n = PING;
      end
      PING: begin
        if (!tx_pending) begin
          state_n = IDLE;
          retry_n = '0;
        end else if (ping_fire) begin
          state_n = WAIT;
          wait_n  = WAIT_W'(1);
        end
      end
      WAIT: begin
        if (rx_resp && rx_pkt.src == RESP_GRANT) begin
          state_n   = GRANTED;
          tx_flag_n = 1'b1;
          retry_n   = '0;
        end else if (rx_resp || wait_cnt == WAIT_W'(RESP_TIMEOUT)) begin
          if (retry_cnt == RETRY_W'(MAX_RETRY - 1)) begin
            fail_n  = 1'b1;
            retry_n = '0;
            state_n = IDLE;
          end else begin
            retry_n = retry_cnt + RETRY_W'(1);
            bo_n    = '0;
            state_n = (BACKOFF_SLOTS == 0) ? IDLE : BACKOFF;
          end
        end else begin
          wait_n = wait_cnt + WAIT_W'(1);
        end
      end
      GRANTED: begin
        if (data_tx_complete_flag) begin
          tx_flag_n = 1'b0;
          state_n   = IDLE;
        end
      end
      BACKOFF: begin
        // An own slot counts as skipped only if its first cycle was seen here.
        if (!tx_pending) begin
          state_n = IDLE;
          retry_n = '0;
        end else if (own_slot && slot_wrap && bo_cnt >= BO_W'(BACKOFF_SLOTS)) begin
          state_n = IDLE;
        end else if (own_slot && cyc == '0) begin
          bo_n = bo_cnt + BO_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      retry_cnt    <= '0;
      wait_cnt     <= '0;
      bo_cnt       <= '0;
      data_tx_flag <= 1'b0;
      tx_fail      <= 1'b0;
    end else begin
      state        <= state_n;
      retry_cnt    <= retry_n;
      wait_cnt     <= wait_n;
      bo_cnt       <= bo_n;
      data_tx_flag <= tx_flag_n;
      tx_fail      <= fail_n;
    end
  end

  // ---------------- GPP transfer window ----------------
  // Free slots before the own slot; a borrow out of ID_W+1 bits means wrap by max_node.
  logic [ID_W:0] free_raw;
  logic [ID_W:0] free_slots;

  always_comb begin
    free_raw   = {1'b0, node_id} - {1'b0, slot} - (ID_W+1)'(1);
    free_slots = free_raw;
    if (free_raw[ID_W]) free_slots = free_raw + {1'b0, max_node};
    if (own_slot)       free_slots = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gpp_trf_cp <= 1'b0;
    end else begin
      gpp_trf_cp <= (state == IDLE) && !data_tx_flag &&
                    (free_slots >= (ID_W+1)'(TRF_MIN_SLOTS));
    end
  end

endmodule

// File: tb/tb_control_plane_tdm.sv
// Self-checking bench for control_plane_tdm: directed scenarios plus randomized
// rx traffic against a slot/response reference model (node 2 of 4, 3 cycles per slot).
module tb_control_plane_tdm;

  localparam int NODE   = 2;
  localparam int NODES  = 4;
  localparam int SLOTC  = 3;
  localparam int ROUND  = NODES * SLOTC;
  localparam int TMO    = 8;
  localparam int BOFF   = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] node_id = 16'(NODE);
  logic [15:0] max_node = 16'(NODES);
  logic [31:0] control_rx_packet = '0;
  logic        tx_pending = 1'b0;
  logic [15:0] tx_dest_id = '0;
  logic        data_tx_complete_flag = 1'b0;
  logic        data_rx_complete_flag = 1'b0;
  logic        gpp_rtr_cp = 1'b0;
  logic [31:0] control_tx_packet;
  logic [15:0] data_rx_node_id;
  logic        data_tx_flag;
  logic        data_rx_flag;
  logic        tx_fail;
  logic        gpp_trf_cp;

  control_plane_tdm dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .node_id               (node_id),
    .max_node              (max_node),
    .control_rx_packet     (control_rx_packet),
    .tx_pending            (tx_pending),
    .tx_dest_id            (tx_dest_id),
    .data_tx_complete_flag (data_tx_complete_flag),
    .data_rx_complete_flag (data_rx_complete_flag),
    .gpp_rtr_cp            (gpp_rtr_cp),
    .control_tx_packet     (control_tx_packet),
    .data_rx_node_id       (data_rx_node_id),
    .data_tx_flag          (data_tx_flag),
    .data_rx_flag          (data_rx_flag),
    .tx_fail               (tx_fail),
    .gpp_trf_cp            (gpp_trf_cp)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int k       = 0;   // clock edges since reset release

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, k);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    control_rx_packet = '0;
    tx_pending = 1'b0;
    tx_dest_id = '0;
    data_tx_complete_flag = 1'b0;
    data_rx_complete_flag = 1'b0;
    gpp_rtr_cp = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    k = 0;
  endtask

  function automatic int slot_of(input int cyc_idx);
    return ((cyc_idx / SLOTC) % NODES) + 1;
  endfunction

  // Idle-node GPP window: at least two free slots before the own slot.
  function automatic logic trf_exp(input int slot);
    int f;
    f = (((NODE - slot - 1) % NODES) + NODES) % NODES;
    if (slot == NODE) f = 0;
    return f >= 2;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_tx"},     control_tx_packet, 32'h0);
    check({tag, "_rxnode"}, {16'h0, data_rx_node_id}, 32'h0);
    check({tag, "_txflag"}, {31'h0, data_tx_flag}, 32'h0);
    check({tag, "_rxflag"}, {31'h0, data_rx_flag}, 32'h0);
    check({tag, "_fail"},   {31'h0, tx_fail}, 32'h0);
    check({tag, "_trf"},    {31'h0, gpp_trf_cp}, 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    logic found;
    int pings[$];
    int fails;
    int fail_k;
    logic m_busy, m_prev;
    logic [15:0] m_node;
    logic [15:0] src, dst;
    logic ping, grant;
    logic [31:0] exp_tx;
    logic exp_trf;

    // ---- reset state ----
    #1;
    check_all_zero("reset");

    // ---- 1: ping, grant two cycles later, then data tx completes ----
    do_reset();
    tx_pending = 1'b1;
    tx_dest_id = 16'd3;
    found = 1'b0;
    guard = 0;
    while (!found && guard < 40) begin
      tick();
      guard++;
      if (control_tx_packet == 32'h0003_0002) found = 1'b1;
    end
    check("t1_ping_seen", {31'h0, found}, 32'h1);
    check("t1_ping_cycle", k, SLOTC * (NODE - 1) + 1);
    check("t1_ping_slot", slot_of(k), NODE);
    tick();
    tick();
    control_rx_packet = 32'h0002_FFFF;
    check("t1_flag_before", {31'h0, data_tx_flag}, 32'h0);
    tick();
    control_rx_packet = '0;
    tx_pending = 1'b0;
    check("t1_granted", {31'h0, data_tx_flag}, 32'h1);
    data_tx_complete_flag = 1'b1;
    tick();
    data_tx_complete_flag = 1'b0;
    check("t1_complete", {31'h0, data_tx_flag}, 32'h0);

    // ---- 2: incoming ping granted, back-to-back ping denied ----
    do_reset();
    tick();
    tick();
    control_rx_packet = 32'h0002_0004;
    tick();
    control_rx_packet = 32'h0002_0001;
    check("t2_grant_pkt", control_tx_packet, 32'h0004_FFFF);
    check("t2_rxflag", {31'h0, data_rx_flag}, 32'h1);
    check("t2_rxnode", {16'h0, data_rx_node_id}, 32'h4);
    tick();
    control_rx_packet = '0;
    check("t2_deny_pkt", control_tx_packet, 32'h0001_0000);
    check("t2_rxnode_kept", {16'h0, data_rx_node_id}, 32'h4);
    data_rx_complete_flag = 1'b1;
    tick();
    data_rx_complete_flag = 1'b0;
    check("t2_rx_done", {31'h0, data_rx_flag}, 32'h0);

    // ---- 3: GPP reading rx RAM forces a deny ----
    do_reset();
    tick();
    gpp_rtr_cp = 1'b1;
    control_rx_packet = 32'h0002_0003;
    tick();
    gpp_rtr_cp = 1'b0;
    control_rx_packet = '0;
    check("t3_deny_pkt", control_tx_packet, 32'h0003_0000);
    check("t3_rxflag", {31'h0, data_rx_flag}, 32'h0);

    // ---- 4: destination never answers ----
    do_reset();
    tx_pending = 1'b1;
    tx_dest_id = 16'd3;
    fails = 0;
    fail_k = -1;
    pings.delete();
    for (int c = 0; c < 110; c++) begin
      tick();
      if (control_tx_packet == 32'h0003_0002) pings.push_back(k);
      if (tx_fail) begin
        fails++;
        if (fail_k < 0) fail_k = k;
        tx_pending = 1'b0;
      end
      if (fail_k >= 0 && k >= fail_k + 2)
        check("t4_idle_trf", {31'h0, gpp_trf_cp}, {31'h0, trf_exp(slot_of(k - 1))});
    end
    check("t4_ping_count", pings.size(), 3);
    for (int i = 0; i < pings.size() && i < 3; i++)
      check("t4_ping_cycle", pings[i], SLOTC * (NODE - 1) + 1 + i * (1 + BOFF) * ROUND);
    check("t4_fail_count", fails, 1);
    check("t4_fail_cycle", fail_k, SLOTC * (NODE - 1) + 1 + 2 * (1 + BOFF) * ROUND + TMO + 1);

    // ---- 5: response pre-empts own ping, ping follows in the next own-slot cycle ----
    do_reset();
    tx_pending = 1'b1;
    tx_dest_id = 16'd3;
    tick();
    tick();
    tick();
    control_rx_packet = 32'h0002_0003;
    tick();
    control_rx_packet = '0;
    check("t5_resp_first", control_tx_packet, 32'h0003_FFFF);
    tick();
    check("t5_ping_next", control_tx_packet, 32'h0003_0002);
    check("t5_ping_slot", slot_of(k), NODE);

    // ---- 6: gpp_trf_cp slot sweep, then async reset mid-WAIT ----
    do_reset();
    for (int c = 0; c < ROUND; c++) begin
      exp_trf = trf_exp(slot_of(k));
      tick();
      check("t6_trf", {31'h0, gpp_trf_cp}, {31'h0, exp_trf});
    end
    control_rx_packet = 32'h0002_0001;
    tick();
    control_rx_packet = '0;
    tx_pending = 1'b1;
    tx_dest_id = 16'd3;
    found = 1'b0;
    guard = 0;
    while (!found && guard < 40) begin
      tick();
      guard++;
      if (control_tx_packet == 32'h0003_0002) found = 1'b1;
    end
    check("t6_ping_seen", {31'h0, found}, 32'h1);
    tick();
    tick();
    check("t6_rxflag_pre", {31'h0, data_rx_flag}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("t6_async_rst");

    // ---- random rx traffic against the reference model (tx side idle) ----
    do_reset();
    m_busy = 1'b0;
    m_prev = 1'b0;
    m_node = '0;
    for (int c = 0; c < 300; c++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: begin
          case ($urandom_range(0, 5))
            0: src = 16'h0000;
            1: src = 16'hFFFF;
            2: src = 16'd1;
            3: src = 16'd3;
            4: src = 16'd4;
            default: src = 16'($urandom);
          endcase
          dst = 16'(NODE);
        end
        4, 5: begin
          dst = 16'($urandom_range(0, 5));
          src = 16'($urandom);
        end
        default: begin
          dst = '0;
          src = '0;
        end
      endcase
      control_rx_packet = {dst, src};
      gpp_rtr_cp = ($urandom_range(0, 3) == 0);
      data_rx_complete_flag = ($urandom_range(0, 4) == 0);

      ping   = (dst == 16'(NODE)) && (src != 16'h0000) && (src != 16'hFFFF);
      grant  = ping && !m_busy && !gpp_rtr_cp && !m_prev;
      exp_tx = ping ? {src, grant ? 16'hFFFF : 16'h0000} : 32'h0;
      if (grant) begin
        m_busy = 1'b1;
        m_node = src;
      end else if (data_rx_complete_flag) begin
        m_busy = 1'b0;
      end
      m_prev  = ping;
      exp_trf = trf_exp(slot_of(k));

      tick();
      check("rnd_tx", control_tx_packet, exp_tx);
      check("rnd_rxflag", {31'h0, data_rx_flag}, {31'h0, m_busy});
      check("rnd_rxnode", {16'h0, data_rx_node_id}, {16'h0, m_node});
      check("rnd_trf", {31'h0, gpp_trf_cp}, {31'h0, exp_trf});
    end
    control_rx_packet = '0;
    gpp_rtr_cp = 1'b0;
    data_rx_complete_flag = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
